// File: rtl/sparc_alu_pkg.sv
// Shared ALU record types, widths and MISR taps for the ALU capture path.
package sparc_alu_pkg;

    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int ICC_W  = 4;
    localparam int REC_W  = OP_W + DATA_W + ICC_W;

    localparam int MISR_TAP3 = 31;
    localparam int MISR_TAP2 = 21;
    localparam int MISR_TAP1 = 1;
    localparam int MISR_TAP0 = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] res;
        logic [ICC_W-1:0]  icc;   // {N,Z,V,C}
    } alu_rec_t;

    // One MISR step: shift in the tap feedback, then fold in result, icc and opcode.
    function automatic logic [DATA_W-1:0] misr_next(input logic [DATA_W-1:0] sig,
                                                    input alu_rec_t          rec);
        logic fb;
        fb = sig[MISR_TAP3] ^ sig[MISR_TAP2] ^ sig[MISR_TAP1] ^ sig[MISR_TAP0];
        return {sig[DATA_W-2:0], fb} ^ rec.res
               ^ {{(DATA_W-ICC_W-OP_W){1'b0}}, rec.icc, rec.op};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; write-to-read latency 1 cycle, no bypass.
// Backpressure via full/empty; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 42
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   occ;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (occ == (ADDR_W+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;
    assign rd_dat  = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + (ADDR_W+1)'(1);
                2'b01:   occ <= occ - (ADDR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once occupancy covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/alu_result_collector.sv
// ALU capture end: buffers {op,res,icc} records, drains them over valid/ready, keeps count + MISR.
// Latency 1 cycle push-to-head; in_ready = !full (no push on a full cycle even with a pop), overflow sets dropped.
module alu_result_collector
    import sparc_alu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_res,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_v,
    input  logic              in_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_res,
    output logic [ICC_W-1:0]  out_icc,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] signature,
    output logic              dropped
);

    alu_rec_t         in_rec;
    alu_rec_t         head_rec;
    logic [REC_W-1:0] head_dat;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign in_rec    = {in_op, in_res, in_n, in_z, in_v, in_c};
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    // clear wins over both handshakes in the same cycle.
    assign push      = in_valid & in_ready & ~clear;
    assign pop       = out_valid & out_ready & ~clear;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wr_dat (in_rec),
        .rd_dat (head_dat),
        .full   (full),
        .empty  (empty)
    );

    // Stale storage is masked so the read port shows zeros while empty.
    assign head_rec = out_valid ? alu_rec_t'(head_dat) : '0;
    assign out_op   = head_rec.op;
    assign out_res  = head_rec.res;
    assign out_icc  = head_rec.icc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            signature <= '0;
            dropped   <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            signature <= '0;
            dropped   <= 1'b0;
        end else begin
            if (push) begin
                signature <= misr_next(signature, in_rec);
                if (count != '1) count <= count + CNT_W'(1);
            end
            if (in_valid && full) dropped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: directed cases plus a randomised-ready opcode sweep.
module tb_alu_result_collector;
    import sparc_alu_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  in_op = '0;
    logic [31:0] in_res = '0;
    logic        in_n = 1'b0, in_z = 1'b0, in_v = 1'b0, in_c = 1'b0;
    logic        in_ready, out_valid, dropped;
    logic [5:0]  out_op;
    logic [31:0] out_res, signature;
    logic [3:0]  out_icc;
    logic [7:0]  count;

    always #5 clk = ~clk;

    alu_result_collector #(.DEPTH(8), .ADDR_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_res(in_res),
        .in_n(in_n), .in_z(in_z), .in_v(in_v), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_res(out_res), .out_icc(out_icc),
        .count(count), .signature(signature), .dropped(dropped)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    alu_rec_t    sb_q[$];
    logic [31:0] m_sig = '0;
    logic [7:0]  m_cnt = '0;

    localparam logic [5:0] OPS [23] = '{
        6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0A, 6'h0B, 6'h0C,
        6'h0E, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18};
    localparam logic [31:0] OPA [5] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h80000000};
    localparam logic [31:0] OPB [5] = '{32'h0, 32'h1, 32'h1, 32'h9ABCDEF0, 32'hFFFFFFFF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gold_misr(input logic [31:0] s, input logic [5:0] op,
                                              input logic [31:0] res, input logic [3:0] icc);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb} ^ res ^ {22'b0, icc, op};
    endfunction

    // Model of the FIFO: decides acceptance from its own occupancy, checks handshakes and drain order.
    initial begin
        alu_rec_t exp_rec;
        bit       accept;
        forever begin
            @(negedge clk);
            if (!rst_n || clear) begin
                sb_q.delete();
                m_sig = '0;
                m_cnt = '0;
            end else begin
                check("in_ready", in_ready, sb_q.size() < DEPTH);
                check("out_valid", out_valid, sb_q.size() != 0);
                accept = in_valid && (sb_q.size() < DEPTH);
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    exp_rec = sb_q.pop_front();
                    check("pop_op", out_op, exp_rec.op);
                    check("pop_res", out_res, exp_rec.res);
                    check("pop_icc", out_icc, exp_rec.icc);
                end
                if (accept) begin
                    sb_q.push_back({in_op, in_res, in_n, in_z, in_v, in_c});
                    m_sig = gold_misr(m_sig, in_op, in_res, {in_n, in_z, in_v, in_c});
                    if (m_cnt != 8'hFF) m_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] res, input logic [3:0] icc);
        in_valid = v;
        in_op    = op;
        in_res   = res;
        {in_n, in_z, in_v, in_c} = icc;
    endtask

    task automatic push_rec(input logic [5:0] op, input logic [31:0] res, input logic [3:0] icc, input bit rnd_rdy);
        bit done = 1'b0;
        drive(1'b1, op, res, icc);
        for (int k = 0; k < 60 && !done; k++) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("push_accept", done, 1'b1);
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (out_valid && k < 40) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        check("drain_done", out_valid, 1'b0);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        logic [31:0] exp_sig;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_count", count, 8'd0);
        check("rst_sig", signature, 32'd0);
        check("rst_dropped", dropped, 1'b0);
        check("rst_head", {out_op, out_res, out_icc}, 42'd0);
        rst_n = 1'b1;
        tick();

        // First record, then a second while the reader stalls
        drive(1'b1, 6'b000001, 32'd5, 4'b0000);
        tick();
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_res", out_res, 32'd5);
        check("t1_count", count, 8'd1);
        check("t1_sig", signature, 32'h00000004);
        drive(1'b1, 6'b000000, 32'hFFFFFFFF, 4'b1000);
        tick();
        drive(1'b0, '0, '0, '0);
        check("t2_sig", signature, 32'hFFFFFDF7);
        check("t2_count", count, 8'd2);
        check("t2_head_res", out_res, 32'd5);
        drain();

        // Fill to DEPTH, then overflow
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 6'(i + 3), 32'h1000 + 32'(i), 4'(i));
            tick();
        end
        exp_sig = m_sig;
        drive(1'b1, 6'h3F, 32'hDEADBEEF, 4'hF);
        check("t3_full", in_ready, 1'b0);
        check("t3_count", count, 8'd8);
        tick();
        check("t3_dropped", dropped, 1'b1);
        check("t3_count_hold", count, 8'd8);
        check("t3_sig_hold", signature, exp_sig);

        // Pop while full does not admit the waiting push until the next cycle
        out_ready = 1'b1;
        tick();
        check("t4_pop_only_cnt", count, 8'd8);
        check("t4_occ7_ready", in_ready, 1'b1);
        out_ready = 1'b0;
        tick();
        drive(1'b0, '0, '0, '0);
        check("t4_push_cnt", count, 8'd9);
        check("t4_full_again", in_ready, 1'b0);
        drain();

        // Opcode sweep with a randomly stalling reader
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_drop_clr", dropped, 1'b0);
        check("t5_cnt_clr", count, 8'd0);
        for (int o = 0; o < 23; o++)
            for (int j = 0; j < 5; j++)
                push_rec(OPS[o], (OPA[j] + OPB[j]) ^ {26'b0, OPS[o]}, 4'($urandom_range(0, 15)), 1'b1);
        drain();
        check("t5_count", count, 8'd115);
        check("t5_sig", signature, m_sig);

        // clear with records buffered, plus an ignored push in the clear cycle
        for (int i = 0; i < 3; i++) push_rec(6'(i), 32'hA0 + 32'(i), 4'h3, 1'b0);
        check("t6_buffered", out_valid, 1'b1);
        clear = 1'b1;
        drive(1'b1, 6'h2A, 32'h55, 4'h1);
        tick();
        clear = 1'b0;
        drive(1'b0, '0, '0, '0);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_count", count, 8'd0);
        check("t6_sig", signature, 32'd0);
        check("t6_dropped", dropped, 1'b0);
        push_rec(6'h02, 32'd7, 4'b0101, 1'b0);
        check("t6_repush_cnt", count, 8'd1);
        check("t6_repush_sig", signature, gold_misr(32'd0, 6'h02, 32'd7, 4'b0101));
        check("t6_repush_res", out_res, 32'd7);

        // Asynchronous reset mid-stream
        push_rec(6'h04, 32'd9, 4'b0010, 1'b0);
        push_rec(6'h05, 32'd11, 4'b0001, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_arst_valid", out_valid, 1'b0);
        check("t6_arst_count", count, 8'd0);
        check("t6_arst_sig", signature, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_rst_valid", out_valid, 1'b0);
        push_rec(6'h10, 32'h1234, 4'b1111, 1'b0);
        check("t6_post_rst_cnt", count, 8'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
